// File: rtl/mag_cmp_seq.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands CHUNK bits per
// cycle, MSB slice first, stopping at the first differing slice.
module mag_cmp_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                is_signed,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                a_eq_b,
    output logic                                a_gt_b,
    output logic                                a_lt_b,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]    slices_used
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int SW     = $clog2(NSLICE + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SW-1:0]    r_used;
    logic [SW-1:0]    r_slices;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic [WIDTH-1:0] w_mask;
    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;

    // Flipping the MSB maps two's complement onto offset binary, so all slice
    // compares below can stay unsigned.
    assign w_mask = WIDTH'(is_signed) << (WIDTH - 1);

    // Operands shift left after each equal slice, so the active slice is always on top.
    assign w_sa = r_a[WIDTH-1 -: CHUNK];
    assign w_sb = r_b[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_used   <= '0;
            r_slices <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a ^ w_mask;
                        r_b     <= b ^ w_mask;
                        r_used  <= SW'(1);
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_sa != w_sb) begin
                        r_gt     <= (w_sa > w_sb);
                        r_lt     <= (w_sa < w_sb);
                        r_slices <= r_used;
                        r_state  <= S_DONE;
                    end else if (r_used == SW'(NSLICE)) begin
                        r_eq     <= 1'b1;
                        r_slices <= r_used;
                        r_state  <= S_DONE;
                    end else begin
                        r_a    <= r_a << CHUNK;
                        r_b    <= r_b << CHUNK;
                        r_used <= r_used + SW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_eq    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign a_eq_b      = r_eq;
    assign a_gt_b      = r_gt;
    assign a_lt_b      = r_lt;
    assign slices_used = r_slices;

endmodule
